// File: rtl/battle_link_if.sv
`default_nettype none
// ============================================================================
// Module      : battle_link_if
// Description : Game-core side bundle of the battle link. It carries the
//               transmit payload handshake and the receive status and payload.
// Revision    : 1.0 - initial release
// ============================================================================
interface battle_link_if #(
    parameter int PAYLOAD_W = 14
);
    logic [PAYLOAD_W-1:0] tx_payload;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [PAYLOAD_W-1:0] rx_payload;
    logic                 rx_valid;
    logic                 rx_err;
    logic [7:0]           err_cnt;
    logic                 link_up;

    // Link block side
    modport slave (
        input  tx_payload, tx_valid,
        output tx_ready, rx_payload, rx_valid, rx_err, err_cnt, link_up
    );

    // Game core side
    modport master (
        output tx_payload, tx_valid,
        input  tx_ready, rx_payload, rx_valid, rx_err, err_cnt, link_up
    );
endinterface
`default_nettype wire

// File: rtl/battle_link.sv
`default_nettype none
// ============================================================================
// Module      : battle_link
// Description : Framed, lane-width-configurable board-to-board battle link.
//               TX serialises a latched payload as NBEAT data beats plus an
//               XOR check beat, with a beat strobe and start-of-frame marker.
//               RX synchronises the peer pins, deserialises, checks the XOR
//               beat and tracks link liveness.
// Revision    : 1.0 - initial release
// ============================================================================
module battle_link #(
    parameter int LANES     = 3,
    parameter int PAYLOAD_W = 14,
    parameter int BEAT      = 8,
    parameter int TIMEOUT   = 1023
) (
    input  wire logic             clk,
    input  wire logic             rst,
    battle_link_if.slave          bus,
    output logic                  link_clk_out,
    output logic                  link_sof_out,
    output logic [LANES-1:0]      link_dat_out,
    input  wire logic             link_clk_in,
    input  wire logic             link_sof_in,
    input  wire logic [LANES-1:0] link_dat_in
);

    localparam int c_NBEAT   = (PAYLOAD_W + LANES - 1) / LANES;
    localparam int c_FRAME_W = c_NBEAT * LANES;
    localparam int c_CW      = $clog2(BEAT);
    localparam int c_BW      = (c_NBEAT > 1) ? $clog2(c_NBEAT) : 1;
    localparam int c_RBW     = $clog2(c_NBEAT + 1);
    localparam int c_TW      = $clog2(TIMEOUT + 1);

    localparam logic [c_CW-1:0]  c_CYC_LAST  = c_CW'(BEAT - 1);
    localparam logic [c_CW-1:0]  c_CYC_HALF  = c_CW'(BEAT / 2);
    localparam logic [c_BW-1:0]  c_BEAT_LAST = c_BW'(c_NBEAT - 1);
    localparam logic [c_RBW-1:0] c_CHK_IDX   = c_RBW'(c_NBEAT);
    localparam logic [c_TW-1:0]  c_TO_MAX    = c_TW'(TIMEOUT);
    localparam logic [c_TW-1:0]  c_TO_HIT    = c_TW'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Transmit side
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SEND  = 2'd1,
        TX_CHECK = 2'd2
    } tx_state_t;

    tx_state_t            r_tx_state;
    tx_state_t            w_tx_state_nxt;
    logic [c_CW-1:0]      r_tx_cyc;
    logic [c_CW-1:0]      w_tx_cyc_nxt;
    logic [c_BW-1:0]      r_tx_beat;
    logic [c_BW-1:0]      w_tx_beat_nxt;
    logic                 w_tx_accept;
    logic [PAYLOAD_W-1:0] r_tx_shadow;
    logic [c_FRAME_W-1:0] w_tx_frame;
    logic [LANES-1:0]     w_tx_sel;
    logic [LANES-1:0]     w_tx_chk;

    // Pad bits above the payload are always sent as zero.
    assign w_tx_frame = c_FRAME_W'(r_tx_shadow);

    // TX state, beat position and latched payload
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state  <= TX_IDLE;
            r_tx_cyc    <= '0;
            r_tx_beat   <= '0;
            r_tx_shadow <= '0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cyc   <= w_tx_cyc_nxt;
            r_tx_beat  <= w_tx_beat_nxt;
            if (w_tx_accept) begin
                r_tx_shadow <= bus.tx_payload;
            end
        end
    end

    // TX next state: walk NBEAT data beats, then one check beat
    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cyc_nxt   = r_tx_cyc;
        w_tx_beat_nxt  = r_tx_beat;
        w_tx_accept    = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (bus.tx_valid) begin
                    w_tx_accept    = 1'b1;
                    w_tx_state_nxt = TX_SEND;
                    w_tx_cyc_nxt   = '0;
                    w_tx_beat_nxt  = '0;
                end
            end
            TX_SEND: begin
                if (r_tx_cyc == c_CYC_LAST) begin
                    w_tx_cyc_nxt = '0;
                    if (r_tx_beat == c_BEAT_LAST) begin
                        w_tx_beat_nxt  = '0;
                        w_tx_state_nxt = TX_CHECK;
                    end else begin
                        w_tx_beat_nxt = r_tx_beat + c_BW'(1);
                    end
                end else begin
                    w_tx_cyc_nxt = r_tx_cyc + c_CW'(1);
                end
            end
            TX_CHECK: begin
                if (r_tx_cyc == c_CYC_LAST) begin
                    w_tx_cyc_nxt   = '0;
                    w_tx_state_nxt = TX_IDLE;
                end else begin
                    w_tx_cyc_nxt = r_tx_cyc + c_CW'(1);
                end
            end
            default: begin
                w_tx_state_nxt = TX_IDLE;
                w_tx_cyc_nxt   = '0;
                w_tx_beat_nxt  = '0;
            end
        endcase
    end

    // Current data beat select and XOR check beat over all data beats
    always_comb begin
        w_tx_sel = '0;
        w_tx_chk = '0;
        for (int k = 0; k < c_NBEAT; k++) begin
            w_tx_chk = w_tx_chk ^ w_tx_frame[k*LANES +: LANES];
            if (r_tx_beat == c_BW'(k)) begin
                w_tx_sel = w_tx_frame[k*LANES +: LANES];
            end
        end
    end

    // Pin outputs are decoded from registered state only, so they are stable
    // for a whole beat and come up the cycle after acceptance.
    assign bus.tx_ready = (r_tx_state == TX_IDLE);
    assign link_clk_out = (r_tx_state != TX_IDLE) && (r_tx_cyc < c_CYC_HALF);
    assign link_sof_out = (r_tx_state == TX_SEND) && (r_tx_beat == '0);
    assign link_dat_out = (r_tx_state == TX_SEND)  ? w_tx_sel :
                          (r_tx_state == TX_CHECK) ? w_tx_chk : '0;

    // ------------------------------------------------------------------------
    // Receive side
    // ------------------------------------------------------------------------
    typedef enum logic {
        RX_HUNT    = 1'b0,
        RX_COLLECT = 1'b1
    } rx_state_t;

    logic [LANES+1:0]     r_sync1;
    logic [LANES+1:0]     r_sync2;
    logic                 r_clk_prev;
    logic                 w_edge_raw;
    logic                 r_edge;
    logic                 r_sof_s;
    logic [LANES-1:0]     r_dat_s;

    rx_state_t            r_rx_state;
    rx_state_t            w_rx_state_nxt;
    logic [c_RBW-1:0]     r_rx_beat;
    logic [c_RBW-1:0]     w_rx_beat_nxt;
    logic [LANES-1:0]     r_rx_xor;
    logic [LANES-1:0]     w_rx_xor_nxt;
    logic [PAYLOAD_W-1:0] r_rx_shadow;
    logic [PAYLOAD_W-1:0] w_rx_shadow_nxt;
    logic [PAYLOAD_W-1:0] r_rx_payload;
    logic [PAYLOAD_W-1:0] w_rx_payload_nxt;
    logic                 r_rx_valid;
    logic                 w_rx_valid_nxt;
    logic                 r_rx_err;
    logic                 w_rx_err_nxt;
    logic                 r_link_up;
    logic                 w_link_up_nxt;
    logic [7:0]           r_err_cnt;
    logic [c_TW-1:0]      r_to_cnt;
    logic                 w_to_hit;
    logic                 w_wr_en;
    logic [c_RBW-1:0]     w_wr_idx;

    assign w_edge_raw = r_sync2[LANES+1] & ~r_clk_prev;

    // Two-flop synchroniser on all peer pins, then registered edge detect
    // with sof and data captured alongside the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_clk_prev <= 1'b0;
            r_edge     <= 1'b0;
            r_sof_s    <= 1'b0;
            r_dat_s    <= '0;
        end else begin
            r_sync1    <= {link_clk_in, link_sof_in, link_dat_in};
            r_sync2    <= r_sync1;
            r_clk_prev <= r_sync2[LANES+1];
            r_edge     <= w_edge_raw;
            r_sof_s    <= r_sync2[LANES];
            r_dat_s    <= r_sync2[LANES-1:0];
        end
    end

    // Liveness counter: cycles since the last edge, counting the edge cycle
    // itself, so link_up drops exactly TIMEOUT cycles after that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (r_edge) begin
            r_to_cnt <= c_TW'(1);
        end else if (r_to_cnt != c_TO_MAX) begin
            r_to_cnt <= r_to_cnt + c_TW'(1);
        end
    end

    // An edge in the same cycle always wins over the timeout.
    assign w_to_hit = ~r_edge && (r_to_cnt == c_TO_HIT);

    // RX state, frame assembly and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state   <= RX_HUNT;
            r_rx_beat    <= '0;
            r_rx_xor     <= '0;
            r_rx_shadow  <= '0;
            r_rx_payload <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_err     <= 1'b0;
            r_link_up    <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_rx_state   <= w_rx_state_nxt;
            r_rx_beat    <= w_rx_beat_nxt;
            r_rx_xor     <= w_rx_xor_nxt;
            r_rx_shadow  <= w_rx_shadow_nxt;
            r_rx_payload <= w_rx_payload_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_rx_err     <= w_rx_err_nxt;
            r_link_up    <= w_link_up_nxt;
            if (w_rx_err_nxt && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // RX next state: hunt for sof, collect data beats, verify check beat
    always_comb begin
        w_rx_state_nxt   = r_rx_state;
        w_rx_beat_nxt    = r_rx_beat;
        w_rx_xor_nxt     = r_rx_xor;
        w_rx_shadow_nxt  = r_rx_shadow;
        w_rx_payload_nxt = r_rx_payload;
        w_rx_valid_nxt   = 1'b0;
        w_rx_err_nxt     = 1'b0;
        w_link_up_nxt    = r_link_up;
        w_wr_en          = 1'b0;
        w_wr_idx         = '0;
        if (r_edge) begin
            case (r_rx_state)
                RX_HUNT: begin
                    if (r_sof_s) begin
                        w_wr_en        = 1'b1;
                        w_rx_xor_nxt   = r_dat_s;
                        w_rx_beat_nxt  = c_RBW'(1);
                        w_rx_state_nxt = RX_COLLECT;
                    end
                end
                RX_COLLECT: begin
                    if (r_sof_s) begin
                        // New frame started early: report and restart on it.
                        w_rx_err_nxt  = 1'b1;
                        w_wr_en       = 1'b1;
                        w_rx_xor_nxt  = r_dat_s;
                        w_rx_beat_nxt = c_RBW'(1);
                    end else if (r_rx_beat == c_CHK_IDX) begin
                        if (r_dat_s == r_rx_xor) begin
                            w_rx_payload_nxt = r_rx_shadow;
                            w_rx_valid_nxt   = 1'b1;
                            w_link_up_nxt    = 1'b1;
                        end else begin
                            w_rx_err_nxt = 1'b1;
                        end
                        w_rx_beat_nxt  = '0;
                        w_rx_state_nxt = RX_HUNT;
                    end else begin
                        w_wr_en       = 1'b1;
                        w_wr_idx      = r_rx_beat;
                        w_rx_xor_nxt  = r_rx_xor ^ r_dat_s;
                        w_rx_beat_nxt = r_rx_beat + c_RBW'(1);
                    end
                end
                default: begin
                    w_rx_state_nxt = RX_HUNT;
                    w_rx_beat_nxt  = '0;
                end
            endcase
        end else if (w_to_hit) begin
            w_link_up_nxt  = 1'b0;
            w_rx_beat_nxt  = '0;
            w_rx_state_nxt = RX_HUNT;
        end
        // Scatter the captured beat into its payload bit positions; pad
        // positions above the payload are simply not stored.
        for (int b = 0; b < PAYLOAD_W; b++) begin
            if (w_wr_en && (w_wr_idx == c_RBW'(b / LANES))) begin
                w_rx_shadow_nxt[b] = r_dat_s[b % LANES];
            end
        end
    end

    assign bus.rx_payload = r_rx_payload;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.rx_err     = r_rx_err;
    assign bus.err_cnt    = r_err_cnt;
    assign bus.link_up    = r_link_up;

endmodule
`default_nettype wire

// File: tb/tb_battle_link.sv
`default_nettype none
// ============================================================================
// Module      : tb_battle_link
// Description : Self-checking bench for battle_link. Default-lane instance in
//               loopback with corruption and a bench-side peer driver, plus
//               LANES=1 and LANES=8 loopback instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_battle_link;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_err;
        logic [13:0] pay;
        int          ecnt;
    } exp_t;

    exp_t        q0[$];
    logic [13:0] q1[$];
    logic [13:0] q2[$];
    exp_t        m0_e;
    logic [13:0] m1_p;
    logic [13:0] m2_p;

    battle_link_if #(.PAYLOAD_W(14)) bif0();
    battle_link_if #(.PAYLOAD_W(14)) bif1();
    battle_link_if #(.PAYLOAD_W(14)) bif2();

    // Default instance: loopback with optional lane corruption or bench peer
    logic       l0_clk_o, l0_sof_o;
    logic [2:0] l0_dat_o;
    logic       bsel = 1'b0, b_clk = 1'b0, b_sof = 1'b0;
    logic [2:0] b_dat = 3'b0, cmask = 3'b0;
    logic       l0_clk_i, l0_sof_i;
    logic [2:0] l0_dat_i;
    int         last_rise = 0;

    assign l0_clk_i = bsel ? b_clk : l0_clk_o;
    assign l0_sof_i = bsel ? b_sof : l0_sof_o;
    assign l0_dat_i = bsel ? b_dat : (l0_dat_o ^ cmask);

    battle_link #(.LANES(3), .PAYLOAD_W(14), .BEAT(8), .TIMEOUT(1023)) u0 (
        .clk(clk), .rst(rst), .bus(bif0),
        .link_clk_out(l0_clk_o), .link_sof_out(l0_sof_o), .link_dat_out(l0_dat_o),
        .link_clk_in(l0_clk_i), .link_sof_in(l0_sof_i), .link_dat_in(l0_dat_i)
    );

    logic       l1_clk, l1_sof;
    logic [0:0] l1_dat;
    battle_link #(.LANES(1), .PAYLOAD_W(14), .BEAT(8), .TIMEOUT(1023)) u1 (
        .clk(clk), .rst(rst), .bus(bif1),
        .link_clk_out(l1_clk), .link_sof_out(l1_sof), .link_dat_out(l1_dat),
        .link_clk_in(l1_clk), .link_sof_in(l1_sof), .link_dat_in(l1_dat)
    );

    logic       l2_clk, l2_sof;
    logic [7:0] l2_dat;
    battle_link #(.LANES(8), .PAYLOAD_W(14), .BEAT(8), .TIMEOUT(1023)) u2 (
        .clk(clk), .rst(rst), .bus(bif2),
        .link_clk_out(l2_clk), .link_sof_out(l2_sof), .link_dat_out(l2_dat),
        .link_clk_in(l2_clk), .link_sof_in(l2_sof), .link_dat_in(l2_dat)
    );

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Bench-side peer frame for LANES=3: 15 frame bits, pad bit zero
    function automatic logic [2:0] beat_of(input logic [13:0] p, input int k);
        logic [14:0] f;
        f = {1'b0, p};
        return f[k*3 +: 3];
    endfunction

    function automatic logic [2:0] chk_of(input logic [13:0] p);
        logic [2:0] x;
        x = 3'b0;
        for (int k = 0; k < 5; k++) x = x ^ beat_of(p, k);
        return x;
    endfunction

    // Scoreboard monitors: pop and compare on every RX pulse
    always @(negedge clk) begin
        if (!rst && (bif0.rx_valid || bif0.rx_err)) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL u0_unexpected_pulse: got valid=%0b err=%0b expected none",
                         bif0.rx_valid, bif0.rx_err);
            end else begin
                m0_e = q0.pop_front();
                check("u0_pulse_kind", {30'b0, bif0.rx_err, bif0.rx_valid},
                      m0_e.is_err ? 32'd2 : 32'd1);
                check("u0_rx_payload", {18'b0, bif0.rx_payload}, {18'b0, m0_e.pay});
                check("u0_err_cnt", {24'b0, bif0.err_cnt}, m0_e.ecnt);
                if (!m0_e.is_err) check("u0_link_up_on_good", {31'b0, bif0.link_up}, 1);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (bif1.rx_valid || bif1.rx_err)) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL u1_unexpected_pulse: got valid=%0b err=%0b expected none",
                         bif1.rx_valid, bif1.rx_err);
            end else begin
                m1_p = q1.pop_front();
                check("u1_rx_valid", {31'b0, bif1.rx_valid}, 1);
                check("u1_rx_payload", {18'b0, bif1.rx_payload}, {18'b0, m1_p});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (bif2.rx_valid || bif2.rx_err)) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL u2_unexpected_pulse: got valid=%0b err=%0b expected none",
                         bif2.rx_valid, bif2.rx_err);
            end else begin
                m2_p = q2.pop_front();
                check("u2_rx_valid", {31'b0, bif2.rx_valid}, 1);
                check("u2_rx_payload", {18'b0, bif2.rx_payload}, {18'b0, m2_p});
            end
        end
    end

    // One peer beat: strobe high for 4 cycles, low for 4, sof/data held
    task automatic drv_beat(input logic sof, input logic [2:0] dat);
        @(posedge clk);
        #1;
        b_clk = 1'b1; b_sof = sof; b_dat = dat; last_rise = cyc;
        repeat (4) @(posedge clk);
        #1 b_clk = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic drv_frame(input logic [13:0] p, input int nb);
        for (int k = 0; k < nb; k++) begin
            drv_beat(k == 0, (k < 5) ? beat_of(p, k) : chk_of(p));
        end
        b_sof = 1'b0;
        b_dat = 3'b0;
    endtask

    // Loopback send on u0; optionally invert lane 0 during one beat
    task automatic send_tx(input logic [13:0] p, input int bad_beat, input bit chk_rdy);
        int low;
        low = 0;
        @(negedge clk);
        bif0.tx_payload = p;
        bif0.tx_valid   = 1'b1;
        @(posedge clk);
        #1;
        bif0.tx_valid   = 1'b0;
        bif0.tx_payload = ~p;
        for (int k = 0; k < 6; k++) begin
            cmask = (k == bad_beat) ? 3'b001 : 3'b000;
            for (int c = 0; c < 8; c++) begin
                if (bif0.tx_ready == 1'b0) low++;
                @(posedge clk);
                #1;
            end
        end
        cmask = 3'b000;
        if (chk_rdy) begin
            check("u0_tx_ready_low_cycles", low, 48);
            check("u0_tx_ready_back", {31'b0, bif0.tx_ready}, 1);
        end
    endtask

    task automatic drain0(input string name);
        int n;
        n = 0;
        while (q0.size() != 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d pending responses expected 0", name, q0.size());
            q0.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        bif0.tx_valid = 1'b0; bif0.tx_payload = '0;
        bif1.tx_valid = 1'b0; bif1.tx_payload = '0;
        bif2.tx_valid = 1'b0; bif2.tx_payload = '0;

        // Reset values
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_ready", {31'b0, bif0.tx_ready}, 1);
        check("rst_link_out", {27'b0, l0_clk_o, l0_sof_o, l0_dat_o}, 0);
        check("rst_rx_payload", {18'b0, bif0.rx_payload}, 0);
        check("rst_rx_pulses", {30'b0, bif0.rx_valid, bif0.rx_err}, 0);
        check("rst_err_cnt", {24'b0, bif0.err_cnt}, 0);
        check("rst_link_up", {31'b0, bif0.link_up}, 0);
        @(negedge clk) rst = 1'b0;

        // Loopback good frame
        q0.push_back('{1'b0, 14'h2A5B, 0});
        send_tx(14'h2A5B, -1, 1'b1);
        drain0("drain_loopback");
        check("loop_link_up", {31'b0, bif0.link_up}, 1);
        check("loop_err_cnt", {24'b0, bif0.err_cnt}, 0);

        // Lane 0 inverted during beat 2
        q0.push_back('{1'b1, 14'h2A5B, 1});
        send_tx(14'h0001, 2, 1'b0);
        drain0("drain_corrupt");
        check("corrupt_payload_held", {18'b0, bif0.rx_payload}, 32'h2A5B);
        check("corrupt_err_cnt", {24'b0, bif0.err_cnt}, 1);

        // Bench peer: sof=0 edges in HUNT ignored, abort at beat 3, good frame
        bsel = 1'b1;
        repeat (4) @(posedge clk);
        drv_beat(1'b0, 3'b101);
        drv_beat(1'b0, 3'b010);
        q0.push_back('{1'b1, 14'h2A5B, 2});
        q0.push_back('{1'b0, 14'h1234, 2});
        drv_frame(14'h1234, 3);
        drv_frame(14'h1234, 6);
        drain0("drain_abort");
        check("abort_err_cnt", {24'b0, bif0.err_cnt}, 2);
        check("abort_link_up", {31'b0, bif0.link_up}, 1);

        // Partial frame then silence: timeout drops link without rx_err
        drv_frame(14'h0777, 2);
        n = 0;
        while (bif0.link_up && n < 1200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("timeout_cycle", cyc, last_rise + 3 + 1023);
        check("timeout_link_down", {31'b0, bif0.link_up}, 0);
        q0.push_back('{1'b0, 14'h0ABC, 2});
        drv_frame(14'h0ABC, 6);
        drain0("drain_relink");
        check("relink_link_up", {31'b0, bif0.link_up}, 1);
        bsel = 1'b0;
        repeat (4) @(posedge clk);

        // Reset during beat 2 of a loopback frame
        @(negedge clk);
        bif0.tx_payload = 14'h1555;
        bif0.tx_valid   = 1'b1;
        @(posedge clk);
        #1 bif0.tx_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_tx_ready", {31'b0, bif0.tx_ready}, 1);
        check("midrst_link_out", {27'b0, l0_clk_o, l0_sof_o, l0_dat_o}, 0);
        check("midrst_err_cnt", {24'b0, bif0.err_cnt}, 0);
        check("midrst_rx_payload", {18'b0, bif0.rx_payload}, 0);
        repeat (80) @(posedge clk);
        #1;
        check("midrst_link_up", {31'b0, bif0.link_up}, 0);

        // err_cnt saturation over 260 corrupted frames
        for (int i = 0; i < 260; i++) begin
            q0.push_back('{1'b1, 14'h0000, (i + 1 > 255) ? 255 : i + 1});
            send_tx(14'(i * 37 + 1), 2, 1'b0);
        end
        drain0("drain_saturate");
        check("sat_err_cnt", {24'b0, bif0.err_cnt}, 255);

        // LANES=8: two data beats, pad bits zero, back-to-back frames
        q2.push_back(14'h3FFF);
        q2.push_back(14'h0000);
        @(negedge clk);
        bif2.tx_payload = 14'h3FFF;
        bif2.tx_valid   = 1'b1;
        @(posedge clk);
        #1 bif2.tx_payload = 14'h0000;
        check("u2_beat0", {22'b0, l2_clk, l2_sof, l2_dat}, 32'h3FF);
        repeat (8) @(posedge clk);
        #1 check("u2_beat1_pad", {22'b0, l2_clk, l2_sof, l2_dat}, 32'h23F);
        repeat (8) @(posedge clk);
        #1 check("u2_check_beat", {22'b0, l2_clk, l2_sof, l2_dat}, 32'h2C0);
        n = 0;
        while (!bif2.tx_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1 bif2.tx_valid = 1'b0;
        check("u2_second_accepted", {31'b0, bif2.tx_ready}, 0);

        // LANES=1: fourteen data beats, 120-cycle frame, back-to-back
        q1.push_back(14'h3FFF);
        q1.push_back(14'h0000);
        @(negedge clk);
        bif1.tx_payload = 14'h3FFF;
        bif1.tx_valid   = 1'b1;
        @(posedge clk);
        #1 bif1.tx_payload = 14'h0000;
        n = 0;
        while (!bif1.tx_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("u1_frame_cycles", n, 120);
        @(posedge clk);
        #1 bif1.tx_valid = 1'b0;

        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("sweep_drain", q1.size() + q2.size(), 0);
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
